// File: rtl/credit_bid_scheduler.sv
// -----------------------------------------------------------------------------
// credit_bid_scheduler
//
// Registered N_MST-master bus scheduler. Each requesting master posts a 4-bit
// bid; the highest bid the master can afford from its credit balance wins the
// bus. Equal bids are resolved round-robin starting at rr_ptr. The winner keeps
// the bus until it drops req or reaches MAX_HOLD consecutive grant cycles. One
// idle cycle always separates two ownerships. The winning bid is deducted from
// the winner's balance once, on the IDLE->OWN transition. Every REFILL_PERIOD
// cycles all balances are topped up by REFILL_AMT, saturating at BAL_MAX.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   When defined, a per-master wait counter forces a master that has waited
//   STARVE_LIMIT cycles (and holds at least one credit) to win the next
//   arbitration. Its deduction is clipped to its balance.
//
// Ports
//   clk        in   1             bus clock, all state on rising edge
//   rst        in   1             synchronous active-high reset
//   req        in   N_MST         per-master request level
//   bid        in   4*N_MST       bid[4i+3:4i] = bid of master i
//   grant      out  N_MST         registered one-hot grant, zero = idle
//   owner      out  log2(N_MST)   index of current owner, valid when busy
//   busy       out  1             high while any grant is asserted
//   balance    out  BAL_W*N_MST   live credit per master, slice i = master i
//   refill_pls out  1             high on the cycle refilled balances appear
// -----------------------------------------------------------------------------
module credit_bid_scheduler #(
    parameter int unsigned N_MST         = 4,
    parameter int unsigned BAL_W         = 10,
    parameter int unsigned BAL_INIT      = 750,
    parameter int unsigned BAL_MAX       = 900,
    parameter int unsigned REFILL_AMT    = 750,
    parameter int unsigned REFILL_PERIOD = 400,
    parameter int unsigned MAX_HOLD      = 16,
    parameter int unsigned STARVE_LIMIT  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_MST-1:0]         req,
    input  logic [4*N_MST-1:0]       bid,
    output logic [N_MST-1:0]         grant,
    output logic [$clog2(N_MST)-1:0] owner,
    output logic                     busy,
    output logic [BAL_W*N_MST-1:0]   balance,
    output logic                     refill_pls
);

    localparam int unsigned IW = $clog2(N_MST);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam int unsigned CW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
    localparam int unsigned XW = BAL_W + 1;

    localparam logic [XW-1:0]    REFILL_X  = XW'(REFILL_AMT);
    localparam logic [XW-1:0]    MAX_X     = XW'(BAL_MAX);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(REFILL_PERIOD - 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD);
    localparam logic [BAL_W-1:0] BAL_RST   = BAL_W'(BAL_INIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_OWN  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [N_MST-1:0] grant_nx;
    logic [IW-1:0]    owner_nx;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    rr_nx;
    logic [HW-1:0]    hold_cnt;
    logic [HW-1:0]    hold_nx;
    logic [CW-1:0]    refill_cnt;
    logic             refill_now;

    logic [BAL_W-1:0] bal    [N_MST];
    logic [BAL_W-1:0] bal_nx [N_MST];
    logic [3:0]       bid_v  [N_MST];
    logic [N_MST-1:0] elig;

    logic             any_win;
    logic [IW-1:0]    win;
    logic [3:0]       win_bid;
    logic             take;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned  WW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_SAT = WW'(STARVE_LIMIT);

    logic [WW-1:0]    wait_cnt [N_MST];
    logic [N_MST-1:0] starved;
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_LIMIT == 0);
`endif

    // -------------------------------------------------------------------------
    // Bid extraction, eligibility and output packing
    // -------------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < N_MST; i++) begin
            bid_v[i] = bid[4*i +: 4];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_MST; i++) begin
            elig[i] = req[i] && (bid_v[i] != 4'd0) && (bal[i] >= BAL_W'(bid_v[i]));
        end
    end

    always_comb begin
        balance = '0;
        for (int unsigned i = 0; i < N_MST; i++) begin
            balance[i*BAL_W +: BAL_W] = bal[i];
        end
    end

    assign busy       = |grant;
    assign refill_now = (refill_cnt == CNT_LAST);

`ifdef ARB_STARVE_GUARD_EN
    always_comb begin
        for (int unsigned i = 0; i < N_MST; i++) begin
            starved[i] = req[i] && (wait_cnt[i] >= WAIT_SAT) && (bal[i] != '0);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Winner selection. Scanning upward from rr_ptr and replacing only on a
    // strictly higher bid leaves ties with the first index in round-robin order.
    // -------------------------------------------------------------------------
    always_comb begin
        int unsigned j;
`ifdef ARB_STARVE_GUARD_EN
        logic        st_found;
        st_found = 1'b0;
`endif
        j       = 0;
        any_win = 1'b0;
        win     = '0;
        win_bid = '0;
        for (int unsigned k = 0; k < N_MST; k++) begin
            j = 32'(rr_ptr) + k;
            if (j >= N_MST) begin
                j = j - N_MST;
            end
            if (elig[j] && (!any_win || (bid_v[j] > win_bid))) begin
                any_win = 1'b1;
                win     = IW'(j);
                win_bid = bid_v[j];
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        // A starved master overrides the bid winner; all starved masters carry
        // the same effective bid, so the first one in round-robin order wins.
        for (int unsigned k = 0; k < N_MST; k++) begin
            j = 32'(rr_ptr) + k;
            if (j >= N_MST) begin
                j = j - N_MST;
            end
            if (starved[j] && !st_found) begin
                st_found = 1'b1;
                win      = IW'(j);
                win_bid  = bid_v[j];
            end
        end
        any_win = any_win | st_found;
`endif
    end

    // -------------------------------------------------------------------------
    // FSM next state and registered grant/owner/hold/rr
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        owner_nx = owner;
        hold_nx  = hold_cnt;
        rr_nx    = rr_ptr;
        take     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                grant_nx = '0;
                if (any_win) begin
                    take           = 1'b1;
                    state_nx       = ST_OWN;
                    grant_nx[win]  = 1'b1;
                    owner_nx       = win;
                    hold_nx        = HW'(1);
                end
            end
            ST_OWN: begin
                if (req[owner] && (hold_cnt < HOLD_LAST)) begin
                    hold_nx = hold_cnt + HW'(1);
                end else begin
                    state_nx = ST_IDLE;
                    grant_nx = '0;
                    hold_nx  = '0;
                    rr_nx    = (owner == IW'(N_MST - 1)) ? '0 : owner + IW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
                hold_nx  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Balance update: refill (saturating) first, then deduct the winning bid.
    // Eligibility was judged on the pre-refill balance, and refill never
    // lowers a balance, so the subtraction cannot wrap.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [XW-1:0] sum_x;
        logic [XW-1:0] base_x;
        logic [XW-1:0] ded_x;
        for (int unsigned i = 0; i < N_MST; i++) begin
            sum_x  = {1'b0, bal[i]} + REFILL_X;
            base_x = {1'b0, bal[i]};
            if (refill_now) begin
                base_x = (sum_x > MAX_X) ? MAX_X : sum_x;
            end
            ded_x = '0;
            if (take && (win == IW'(i))) begin
                ded_x = XW'(win_bid);
`ifdef ARB_STARVE_GUARD_EN
                if (ded_x > base_x) begin
                    ded_x = base_x;
                end
`endif
            end
            bal_nx[i] = BAL_W'(base_x - ded_x);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            owner      <= '0;
            hold_cnt   <= '0;
            rr_ptr     <= '0;
            refill_cnt <= '0;
            refill_pls <= 1'b0;
            for (int unsigned i = 0; i < N_MST; i++) begin
                bal[i] <= BAL_RST;
            end
        end else begin
            grant      <= grant_nx;
            owner      <= owner_nx;
            hold_cnt   <= hold_nx;
            rr_ptr     <= rr_nx;
            refill_cnt <= refill_now ? '0 : refill_cnt + CW'(1);
            refill_pls <= refill_now;
            for (int unsigned i = 0; i < N_MST; i++) begin
                bal[i] <= bal_nx[i];
            end
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    // Wait counter saturates at the limit; it only counts cycles spent
    // requesting without holding the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_MST; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_MST; i++) begin
                if (!req[i] || grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] < WAIT_SAT) begin
                    wait_cnt[i] <= wait_cnt[i] + WW'(1);
                end
            end
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant)) else $error("grant is not one-hot or zero");
        end
    end
`endif

endmodule

// File: tb/tb_credit_bid_scheduler.sv
`timescale 1ns/1ps
module tb_credit_bid_scheduler;

    localparam int N             = 4;
    localparam int BAL_W         = 10;
    localparam int BAL_INIT      = 750;
    localparam int BAL_MAX       = 900;
    localparam int REFILL_AMT    = 750;
    localparam int REFILL_PERIOD = 400;
    localparam int MAX_HOLD      = 16;
    localparam int STARVE_LIMIT  = 64;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req = '0;
    logic [4*N-1:0]       bid = '0;
    logic [N-1:0]         grant;
    logic [1:0]           owner;
    logic                 busy;
    logic [BAL_W*N-1:0]   balance;
    logic                 refill_pls;

    always #5 clk = ~clk;

    credit_bid_scheduler #(
        .N_MST(N), .BAL_W(BAL_W), .BAL_INIT(BAL_INIT), .BAL_MAX(BAL_MAX),
        .REFILL_AMT(REFILL_AMT), .REFILL_PERIOD(REFILL_PERIOD),
        .MAX_HOLD(MAX_HOLD), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .bid(bid), .grant(grant),
        .owner(owner), .busy(busy), .balance(balance), .refill_pls(refill_pls)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;   // cycles since reset release

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bid_of(input logic [4*N-1:0] b, input int i);
        logic [3:0] v;
        v = b[4*i +: 4];
        return int'(v);
    endfunction

    function automatic int bal_of(input int i);
        logic [BAL_W-1:0] v;
        v = balance[i*BAL_W +: BAL_W];
        return int'(v);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: owner = -1 means the bus is idle.
    // ------------------------------------------------------------------
    bit m_valid = 0;
    int m_bal[N];
    int m_wait[N];
    int m_owner, m_hold, m_rr, m_cnt;
    bit m_pls;

    task automatic m_step(input bit r, input logic [N-1:0] q, input logic [4*N-1:0] b);
        int  base[N];
        int  w, best, d, i, old_owner;
        bit  refill;
        if (r) begin
            m_valid = 1;
            foreach (m_bal[x]) begin
                m_bal[x]  = BAL_INIT;
                m_wait[x] = 0;
            end
            m_owner = -1; m_hold = 0; m_rr = 0; m_cnt = 0; m_pls = 0;
            return;
        end
        old_owner = m_owner;
        refill = (m_cnt == REFILL_PERIOD - 1);
        m_cnt  = refill ? 0 : m_cnt + 1;
        for (int x = 0; x < N; x++) begin
            base[x] = m_bal[x];
            if (refill) base[x] = (m_bal[x] + REFILL_AMT > BAL_MAX) ? BAL_MAX : m_bal[x] + REFILL_AMT;
        end
        if (m_owner < 0) begin
            w = -1; best = 0;
            for (int s = 0; s < N; s++) begin
                i = (m_rr + s) % N;
                if (q[i] && bid_of(b, i) > best && m_bal[i] >= bid_of(b, i)) begin
                    w = i; best = bid_of(b, i);
                end
            end
`ifdef ARB_STARVE_GUARD_EN
            for (int s = N - 1; s >= 0; s--) begin
                i = (m_rr + s) % N;
                if (q[i] && m_wait[i] >= STARVE_LIMIT && m_bal[i] >= 1) w = i;
            end
`endif
            if (w >= 0) begin
                d = bid_of(b, w);
                if (d > base[w]) d = base[w];
                base[w] -= d;
                m_owner = w;
                m_hold  = 1;
            end
        end else if (q[m_owner] && m_hold < MAX_HOLD) begin
            m_hold++;
        end else begin
            m_rr    = (m_owner + 1) % N;
            m_owner = -1;
        end
        for (int x = 0; x < N; x++) begin
            m_bal[x]  = base[x];
            m_wait[x] = (!q[x] || old_owner == x) ? 0 :
                        (m_wait[x] < STARVE_LIMIT ? m_wait[x] + 1 : m_wait[x]);
        end
        m_pls = refill;
    endtask

    // Compare process: model advances on each edge, DUT checked 1ns later.
    always @(posedge clk) begin
        m_step(rst, req, bid);
        #1;
        if (m_valid) begin
            check("grant", 32'(grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
            check("busy", 32'(busy), 32'(m_owner >= 0));
            if (m_owner >= 0) check("owner", 32'(owner), 32'(m_owner));
            for (int x = 0; x < N; x++) check($sformatf("balance%0d", x), 32'(bal_of(x)), 32'(m_bal[x]));
            check("refill_pls", 32'(refill_pls), 32'(m_pls));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
        k++;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; bid = '0;
        step(); step();
        rst = 1'b0;
        k = 0;
    endtask

    // Grant on one cycle, release on the next: one deduction every 2 cycles.
    task automatic pulse_grants(input int target, output int got);
        got = 0;
        req = 4'b0001;
        while (got < target && k < 300) begin
            step();
            if (busy) begin
                got++;
                req = 4'b0000;
            end else begin
                req = 4'b0001;
            end
        end
    endtask

    initial begin
        int got;
        bit g[40];
        int run;
        bit seen3;

        // T1: reset values and single-master grant
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pls", 32'(refill_pls), 32'd0);
        check("rst_bal3", 32'(bal_of(3)), 32'd750);
        req = 4'b0001; bid = 16'h0005;
        step();
        check("t1_grant", 32'(grant), 32'b0001);
        check("t1_bal0", 32'(bal_of(0)), 32'd745);
        req = 4'b0000;
        step();
        check("t1_release", 32'(grant), 32'd0);

        // T2: tie between masters 1 and 2, then round-robin moves on
        do_reset();
        req = 4'b1111; bid = 16'h2993;
        step();
        check("t2_tie", 32'(grant), 32'b0010);
        for (int n = 0; n < 40 && grant != 0; n++) step();
        check("t2_released", 32'(grant), 32'd0);
        step();
        check("t2_rr", 32'(grant), 32'b0100);

        // T3: hold limit with a continuously requesting master
        do_reset();
        req = 4'b0010; bid = 16'h0040;
        for (int n = 0; n < 40; n++) begin
            step();
            g[n] = grant[1];
        end
        run = 0;
        while (run < 40 && g[run]) run++;
        check("t3_hold_len", 32'(run), 32'd16);
        check("t3_gap", 32'(g[16]), 32'd0);
        check("t3_regrant", 32'(g[17]), 32'd1);
        check("t3_bal1", 32'(bal_of(1)), 32'd738);
        req = '0;

        // T4: credit exhaustion and recovery by refill
        do_reset();
        bid = 16'h000F;
        pulse_grants(50, got);
        check("t4_grants", 32'(got), 32'd50);
        check("t4_bal0_empty", 32'(bal_of(0)), 32'd0);
        req = 4'b0001;
        while (k < 200) step();
        check("t4_starved_idle", 32'(grant), 32'd0);
        while (k < 400) step();
        check("t4_refill_bal", 32'(bal_of(0)), 32'd750);
        check("t4_refill_pls", 32'(refill_pls), 32'd1);
        check("t4_no_grant_yet", 32'(grant), 32'd0);
        step();
        check("t4_regrant", 32'(grant), 32'b0001);
        check("t4_bal_after", 32'(bal_of(0)), 32'd735);
        req = '0;

        // T5: refill and deduction on the same edge
        do_reset();
        bid = 16'h000A;
        pulse_grants(55, got);
        check("t5_bal0_200", 32'(bal_of(0)), 32'd200);
        req = '0;
        while (k < 399) step();
        req = 4'b0001;
        step();
        check("t5_bal0_890", 32'(bal_of(0)), 32'd890);
        check("t5_bal1_900", 32'(bal_of(1)), 32'd900);
        check("t5_pls", 32'(refill_pls), 32'd1);
        check("t5_grant", 32'(grant), 32'b0001);
        req = '0;

        // T6: low bidder against a rich high bidder
        do_reset();
        req = 4'b1001; bid = 16'h100F;
        seen3 = 0;
`ifdef ARB_STARVE_GUARD_EN
        while (!seen3 && k < STARVE_LIMIT + MAX_HOLD + 2) begin
            step();
            if (grant[3]) seen3 = 1;
        end
        check("t6_starve_guard", 32'(seen3), 32'd1);
`else
        for (int n = 0; n < 300; n++) begin
            step();
            if (grant[3]) seen3 = 1;
        end
        check("t6_no_guard", 32'(seen3), 32'd0);
`endif
        req = '0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
